// File: rtl/dot_acc_q15_if.sv
// Product-in / dot-product-out handshake bundle for dot_acc_q15.
// master = upstream/downstream side (drives products and sum_ready), slave = accumulator.
interface dot_acc_q15_if;
  logic [31:0] prod_in;
  logic        prod_valid;
  logic        in_ready;
  logic [15:0] sum_out;
  logic        sum_valid;
  logic        sum_ready;
  logic        drop_err;

  modport master (
    output prod_in, prod_valid, sum_ready,
    input  in_ready, sum_out, sum_valid, drop_err
  );

  modport slave (
    input  prod_in, prod_valid, sum_ready,
    output in_ready, sum_out, sum_valid, drop_err
  );
endinterface

// File: rtl/dot_acc_q15.sv
// Q1.30 product accumulator emitting one rounded/saturated Q0.15 dot product per VEC_LEN accepts.
// Define DOT_ACC_ROUND_EN for round-half-up; default build truncates (floor).
module dot_acc_q15 #(
  parameter int unsigned VEC_LEN = 64,
  parameter int unsigned ACC_W   = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  dot_acc_q15_if.slave bus
);

  localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);
`ifdef DOT_ACC_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(32'sd16384);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  typedef enum logic {ST_ACCUM, ST_HOLD} state_e;

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [15:0]             sum_q;
  logic                    sum_valid_q;
  logic                    drop_err_q;

  logic                    accept_c;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] rounded_c;
  logic signed [ACC_W-1:0] shifted_c;
  logic [15:0]             q15_c;

  // Running total including the current product, and its Q0.15 conversion.
  always_comb begin
    accept_c  = bus.prod_valid && (state_q == ST_ACCUM);
    acc_d     = acc_q + ACC_W'($signed(bus.prod_in));
    rounded_c = acc_d + RND;
    shifted_c = rounded_c >>> 15;
    q15_c     = shifted_c[15:0];
    if (shifted_c > SAT_MAX) begin
      q15_c = 16'h7FFF;
    end else if (shifted_c < SAT_MIN) begin
      q15_c = 16'h8000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      // Upstream cannot stall, so anything offered while holding is lost.
      if (bus.prod_valid && (state_q != ST_ACCUM)) begin
        drop_err_q <= 1'b1;
      end
      case (state_q)
        ST_ACCUM: begin
          if (accept_c) begin
            if (cnt_q == CNT_LAST) begin
              sum_q       <= q15_c;
              sum_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              state_q     <= ST_HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.sum_ready) begin
            sum_valid_q <= 1'b0;
            state_q     <= ST_ACCUM;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.sum_out   = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.drop_err  = drop_err_q;

endmodule

// File: tb/tb_dot_acc_q15.sv
// Directed + randomized bench for dot_acc_q15 (VEC_LEN=4, ACC_W=40) with an arithmetic reference model.
module tb_dot_acc_q15;
  localparam int unsigned VL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_acc_q15_if bus ();

  dot_acc_q15 #(.VEC_LEN(VL), .ACC_W(40)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

`ifdef DOT_ACC_ROUND_EN
  localparam longint RND_REF = 64'sd16384;
`else
  localparam longint RND_REF = 64'sd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact dot product, then floor((sum + R) / 2^15) clamped to 16-bit signed.
  function automatic logic [15:0] ref_dot(input logic [31:0] p [VL]);
    longint s = 0;
    longint q;
    for (int i = 0; i < int'(VL); i++) s += longint'($signed(p[i]));
    q = (s + RND_REF) >>> 15;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic logic [31:0] rand_prod();
    longint v;
    if ($urandom_range(3, 0) == 0)
      v = longint'($urandom_range(65535, 0)) - 64'sd32768;
    else
      v = longint'($urandom_range(32'h8000_0000, 0)) - 64'sd1073741824;
    return v[31:0];
  endfunction

  task automatic send_vec(input logic [31:0] p [VL], input bit gaps);
    for (int i = 0; i < int'(VL); i++) begin
      if (gaps) begin
        repeat ($urandom_range(2, 0)) begin
          bus.prod_valid = 1'b0;
          @(negedge clk);
        end
      end
      bus.prod_valid = 1'b1;
      bus.prod_in    = p[i];
      @(negedge clk);
    end
    bus.prod_valid = 1'b0;
  endtask

  // Bounded wait for sum_valid, check result, then let it drain with sum_ready=1.
  task automatic expect_sum(input string tag, input logic [15:0] exp);
    int n = 0;
    while (bus.sum_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.sum_valid), 32'd1);
    chk(tag, 32'(bus.sum_out), 32'(exp));
    bus.sum_ready = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] pv [VL];

  initial begin
    bus.prod_in    = '0;
    bus.prod_valid = 1'b0;
    bus.sum_ready  = 1'b1;

    // Reset state
    #12;
    chk("rst_sum_out", 32'(bus.sum_out), 32'd0);
    chk("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
    chk("rst_drop_err", 32'(bus.drop_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: one-cycle valid pulse right after the last accept
    pv = '{32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000};
    send_vec(pv, 1'b0);
    chk("basic_valid", 32'(bus.sum_valid), 32'd1);
    chk("basic_sum", 32'(bus.sum_out), 32'h4000);
    chk("basic_in_ready_hold", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("basic_valid_drop", 32'(bus.sum_valid), 32'd0);
    chk("basic_in_ready", 32'(bus.in_ready), 32'd1);

    // Saturation both ways
    pv = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    send_vec(pv, 1'b0);
    expect_sum("sat_pos", 16'h7FFF);
    pv = '{32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000};
    send_vec(pv, 1'b0);
    expect_sum("sat_neg", 16'h8000);

    // Rounding boundary
    pv = '{32'h0000_4000, 32'h0, 32'h0, 32'h0};
    send_vec(pv, 1'b0);
`ifdef DOT_ACC_ROUND_EN
    expect_sum("round_pos_half", 16'h0001);
`else
    expect_sum("round_pos_half", 16'h0000);
`endif
    pv = '{32'hFFFF_C000, 32'h0, 32'h0, 32'h0};
    send_vec(pv, 1'b0);
`ifdef DOT_ACC_ROUND_EN
    expect_sum("round_neg_half", 16'h0000);
`else
    expect_sum("round_neg_half", 16'hFFFF);
`endif

    // Random vectors with bubbles, back-to-back
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < int'(VL); i++) pv[i] = rand_prod();
      send_vec(pv, 1'b1);
      expect_sum($sformatf("rand_vec%0d", v), ref_dot(pv));
    end
    chk("rand_no_drop", 32'(bus.drop_err), 32'd0);

    // Backpressure with products offered during HOLD
    pv = '{32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000};
    bus.sum_ready = 1'b0;
    send_vec(pv, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_sum_c%0d", c), 32'(bus.sum_out), 32'h4000);
      chk($sformatf("bp_valid_c%0d", c), 32'(bus.sum_valid), 32'd1);
      chk($sformatf("bp_in_ready_c%0d", c), 32'(bus.in_ready), 32'd0);
      bus.prod_valid = 1'b1;
      bus.prod_in    = 32'h3FFF_0000;
      @(negedge clk);
    end
    bus.prod_valid = 1'b0;
    chk("bp_drop_err", 32'(bus.drop_err), 32'd1);
    chk("bp_sum_still", 32'(bus.sum_out), 32'h4000);
    expect_sum("bp_release", 16'h4000);
    for (int i = 0; i < int'(VL); i++) pv[i] = rand_prod();
    send_vec(pv, 1'b0);
    expect_sum("bp_next_vec", ref_dot(pv));
    chk("bp_drop_sticky", 32'(bus.drop_err), 32'd1);

    // Reset after two accepts discards the partial sum
    bus.prod_valid = 1'b1;
    bus.prod_in    = 32'h4000_0000;
    @(negedge clk);
    @(negedge clk);
    bus.prod_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sum_out", 32'(bus.sum_out), 32'd0);
    chk("midrst_sum_valid", 32'(bus.sum_valid), 32'd0);
    chk("midrst_drop_err", 32'(bus.drop_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pv = '{32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000};
    send_vec(pv, 1'b0);
    expect_sum("midrst_next", 16'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
